// File: rtl/vga_pkg.sv
// vga_pkg: shared timing constants and helpers for the VGA raster generator.
//   - DEF_*      : default 640x480@60 timing (25 MHz pixel rate from 50 MHz).
//   - h_total    : total pixels per line for a given set of region widths.
//   - v_total    : total lines per frame for a given set of region heights.
//   - cnt_w_ok   : true when a counter of cnt_w bits can hold total-1.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_CNT_W    = 11;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Width limit keeps the shift inside a 32-bit int.
  function automatic bit cnt_w_ok(input int cnt_w, input int total);
    return (cnt_w >= 1) && (cnt_w <= 30) && ((total - 1) < (1 << cnt_w));
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (horizontal or vertical).
// Region order along the axis is active, front porch, sync, back porch.
// Ports:
//   clk      in  : clock
//   rst      in  : synchronous active-high reset, loads the last position
//                  (TOTAL-1) so the first step lands on 0
//   step     in  : advance by one position
//   cnt      out : current position
//   wrap     out : this step moves TOTAL-1 -> 0 (combinational, includes step)
//   active   out : cnt is inside the active region
//   sync_lvl out : POL inside the sync region, ~POL elsewhere
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter bit POL    = 1'b0,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             active,
  output logic             sync_lvl
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACT_END    = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(ACTIVE + FP + SYNC);

  logic at_last;

  assign at_last = (cnt == LAST);
  assign wrap    = step && at_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= LAST;
    end else if (step) begin
      cnt <= at_last ? '0 : cnt + 1'b1;
    end
  end

  assign active   = (cnt < ACT_END);
  assign sync_lvl = ((cnt >= SYNC_START) && (cnt < SYNC_END)) ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Derives the pixel clock enable and VGA_CLK from CLOCK_50, runs the H/V
// raster counters, and delays sync/blank by PIPE pixel periods so they line
// up with a downstream pixel pipeline.
// Ports:
//   CLOCK_50    in  : single clock, everything on its rising edge
//   RESET       in  : synchronous active-high reset, highest priority
//   ENABLE      in  : run (1) / freeze (0) the raster
//   PIX_CE      out : pixel clock enable; counters advance at the end of
//                     the cycle in which it is high (the VGA_CLK falling edge)
//   VGA_CLK     out : pixel clock to the DAC (registered, glitch-free)
//   HCNT_OUT    out : horizontal position
//   VCNT_OUT    out : vertical position
//   IAA_OUT     out : counters are in the active area (not delayed)
//   TC_OUT      out : one-cycle strobe when the counters become (0,0)
//   FRAME_CNT   out : frame number, first frame after reset reads 0
//   VGA_HS/VS   out : syncs, delayed PIPE pixel periods
//   VGA_BLANK_N out : active-area indicator, delayed PIPE pixel periods,
//                     forced low while the raster is frozen
//   VGA_SYNC_N  out : tied low
// There is no valid/ready handshake here: PIX_CE is the only qualifier, and
// consumers of HCNT_OUT/VCNT_OUT/IAA_OUT/TC_OUT treat a value as new on the
// cycle after a PIX_CE cycle.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int PIPE     = 0,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic             ENABLE,
  output logic             PIX_CE,
  output logic             VGA_CLK,
  output logic [CNT_W-1:0] HCNT_OUT,
  output logic [CNT_W-1:0] VCNT_OUT,
  output logic             IAA_OUT,
  output logic             TC_OUT,
  output logic [7:0]       FRAME_CNT,
  output logic             VGA_HS,
  output logic             VGA_VS,
  output logic             VGA_BLANK_N,
  output logic             VGA_SYNC_N
);

  // ---------------------------------------------------------------------
  // Elaboration-time legality checks
  // ---------------------------------------------------------------------
  generate
    if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_clk_div
      $error("vga_timing_gen: CLK_DIV must be even and >= 2");
    end
    if (PIPE < 0 || PIPE > 7) begin : g_bad_pipe
      $error("vga_timing_gen: PIPE must be in 0..7");
    end
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_region
      $error("vga_timing_gen: every region width must be >= 1");
    end
    if (!cnt_w_ok(CNT_W, h_total(H_ACTIVE, H_FP, H_SYNC, H_BP)) ||
        !cnt_w_ok(CNT_W, v_total(V_ACTIVE, V_FP, V_SYNC, V_BP))) begin : g_bad_cnt_w
      $error("vga_timing_gen: CNT_W too small for H_TOTAL-1 / V_TOTAL-1");
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Pixel divider
  // ---------------------------------------------------------------------
  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_next;
  logic             vga_clk_q;
  logic             run_q;
  logic             tc_q;
  logic [7:0]       frame_q;
  logic             pix_ce;

  assign div_next = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
  assign pix_ce   = ENABLE && (div_q == DIV_LAST);

  // ---------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap;
  logic             v_wrap;
  logic             h_active;
  logic             v_active;
  logic             h_sync;
  logic             v_sync;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HS_POL),
    .CNT_W  (CNT_W)
  ) u_h_axis (
    .clk      (CLOCK_50),
    .rst      (RESET),
    .step     (pix_ce),
    .cnt      (h_cnt),
    .wrap     (h_wrap),
    .active   (h_active),
    .sync_lvl (h_sync)
  );

  // V steps on every H wrap; both wrapping together is the frame boundary.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VS_POL),
    .CNT_W  (CNT_W)
  ) u_v_axis (
    .clk      (CLOCK_50),
    .rst      (RESET),
    .step     (h_wrap),
    .cnt      (v_cnt),
    .wrap     (v_wrap),
    .active   (v_active),
    .sync_lvl (v_sync)
  );

  // ---------------------------------------------------------------------
  // Divider, VGA_CLK, frame counter and run flag
  // ---------------------------------------------------------------------
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      div_q     <= '0;
      vga_clk_q <= 1'b0;
      run_q     <= 1'b0;
      tc_q      <= 1'b0;
      frame_q   <= 8'hFF;
    end else begin
      run_q <= ENABLE;
      tc_q  <= v_wrap;
      if (ENABLE) begin
        div_q     <= div_next;
        // Registered from the next divider value so VGA_CLK never glitches.
        vga_clk_q <= (div_next >= DIV_HALF);
      end
      if (v_wrap) begin
        frame_q <= frame_q + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Sync/blank delay pipe, advancing once per pixel
  // ---------------------------------------------------------------------
  logic hs_now;
  logic vs_now;
  logic blank_now;
  logic hs_d;
  logic vs_d;
  logic blank_d;

  assign hs_now    = h_sync;
  assign vs_now    = v_sync;
  assign blank_now = h_active && v_active;

  generate
    if (PIPE == 0) begin : g_no_pipe
      assign hs_d    = hs_now;
      assign vs_d    = vs_now;
      assign blank_d = blank_now;
    end else begin : g_pipe
      // Stage 0 captures the pre-step position, so each stage adds exactly
      // one pixel period of latency.
      logic [2:0] stage_q [PIPE];

      always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
          for (int i = 0; i < PIPE; i++) begin
            stage_q[i] <= {~HS_POL, ~VS_POL, 1'b0};
          end
        end else if (pix_ce) begin
          stage_q[0] <= {hs_now, vs_now, blank_now};
          for (int i = 1; i < PIPE; i++) begin
            stage_q[i] <= stage_q[i-1];
          end
        end
      end

      assign {hs_d, vs_d, blank_d} = stage_q[PIPE-1];
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign PIX_CE      = pix_ce;
  assign VGA_CLK     = vga_clk_q;
  assign HCNT_OUT    = h_cnt;
  assign VCNT_OUT    = v_cnt;
  assign IAA_OUT     = h_active && v_active;
  assign TC_OUT      = tc_q;
  assign FRAME_CNT   = frame_q;
  assign VGA_HS      = hs_d;
  assign VGA_VS      = vs_d;
  assign VGA_BLANK_N = blank_d && run_q;
  assign VGA_SYNC_N  = 1'b0;

endmodule
